// File: rtl/sub_0_pipe.sv
// Two-stage valid/ready subtractor: recovers a W-bit operand from a (W+1)-bit sum.
// Optional build macro SUB_SATURATE_EN clamps diff on borrow/overflow instead of wrapping.
module sub_0_pipe #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       sum,
    input  logic [W-1:0]     a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     diff,
    output logic             borrow,
    output logic             ovf,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic signed [W+1:0] d_p0;
    logic signed [W+1:0] d_p1;
    logic                vld_p1;
    logic                adv_p1;
    logic                adv_p2;
    logic                borrow_p1;
    logic                ovf_p1;
    logic [W-1:0]        diff_p1;
    logic                xfer_p2;

    // Pick the W-bit result from the widened difference.
    function automatic logic [W-1:0] resolve_diff(input logic brw, input logic ov,
                                                  input logic [W-1:0] raw);
`ifdef SUB_SATURATE_EN
        if (brw)
            return '0;
        else if (ov)
            return '1;
        else
            return raw;
`else
        logic unused_flags;
        unused_flags = brw ^ ov;
        return raw;
`endif
    endfunction

    assign d_p0     = $signed({1'b0, sum}) - $signed({2'b00, a});
    assign adv_p2   = ~out_valid | out_ready;
    assign adv_p1   = ~vld_p1 | adv_p2;
    assign in_ready = adv_p1;
    assign xfer_p2  = out_valid & out_ready;

    assign borrow_p1 = d_p1[W+1];
    assign ovf_p1    = ~d_p1[W+1] & d_p1[W];
    assign diff_p1   = resolve_diff(borrow_p1, ovf_p1, d_p1[W-1:0]);

    // Stage 1: widened difference register
    always_ff @(posedge clk) begin
        if (in_valid && adv_p1)
            d_p1 <= d_p0;
    end

    // Control for both stages, output registers and the error counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (adv_p1)
                vld_p1 <= in_valid;
            // Stage 2: result registers drive the ports
            if (adv_p2) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    diff   <= diff_p1;
                    borrow <= borrow_p1;
                    ovf    <= ovf_p1;
                end
            end
            if (xfer_p2 && (borrow || ovf) && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sub_0_pipe.sv
// Scoreboard bench for sub_0_pipe: expected results queued on accept, compared on output transfer.
module tb_sub_0_pipe;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] sum;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic [7:0]  err_cnt;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   err_exp = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    logic stall_pending = 1'b0;
    logic [17:0] held;

    sub_0_pipe #(.W(16), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .a(a), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [16:0] s, input logic [15:0] aa);
        exp_t e;
        int   full;
        full     = int'(s) - int'(aa);
        e.borrow = (full < 0);
        e.ovf    = (full >= 65536);
`ifdef SUB_SATURATE_EN
        if (e.borrow)   e.diff = 16'h0000;
        else if (e.ovf) e.diff = 16'hFFFF;
        else            e.diff = full[15:0];
`else
        e.diff = full[15:0];
`endif
        return e;
    endfunction

    // One clock: drive after the falling edge, then observe the handshake 1 ns later.
    task automatic cycle(input logic v, input logic [16:0] s, input logic [15:0] aa,
                         input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        sum       = s;
        a         = aa;
        out_ready = ordy;
        #1;
        if (stall_pending) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {14'd0, borrow, ovf, diff}, {14'd0, held});
        end
        stall_pending = out_valid && !out_ready;
        held          = {borrow, ovf, diff};
        if (in_valid && in_ready) begin
            sb.push_back(model(s, aa));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff", {16'd0, diff}, {16'd0, e.diff});
                check("flags", {30'd0, borrow, ovf}, {30'd0, e.borrow, e.ovf});
                check("err_cnt", {24'd0, err_cnt}, err_exp);
                if (e.borrow || e.ovf)
                    err_exp = (err_exp < 255) ? err_exp + 1 : 255;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < 20)) begin
            cycle(1'b0, 17'd0, 16'd0, 1'b1);
            n++;
        end
        check("drain_done", sb.size(), 32'd0);
        cycle(1'b0, 17'd0, 16'd0, 1'b1);
    endtask

    task automatic send(input logic [16:0] s, input logic [15:0] aa);
        int n;
        n = 0;
        cycle(1'b1, s, aa, 1'b1);
        while (!in_ready && n < 20) begin
            cycle(1'b1, s, aa, 1'b1);
            n++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        sum       = '0;
        a         = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {13'd0, diff, borrow, ovf}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic pulse and two-edge latency
        cycle(1'b1, 17'd10, 16'd3, 1'b1);
        cycle(1'b0, 17'd0, 16'd0, 1'b1);
        check("lat_edge1", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 17'd0, 16'd0, 1'b1);
        check("lat_edge2", {31'd0, out_valid}, 32'd1);
        drain();

        // Borrow, overflow and boundary cases
        send(17'd5, 16'd9);
        send(17'h1FFFF, 16'd1);
        send(17'd1234, 16'd1234);
        send(17'h0FFFF, 16'd0);
        send(17'h10000, 16'd0);
        send(17'h10000, 16'hFFFF);
        drain();
        check("err_after_flags", {24'd0, err_cnt}, err_exp);

        // Stream 0..9 with a downstream stall
        acc_cnt = 0;
        out_cnt = 0;
        for (int c = 0; c < 40 && acc_cnt < 10; c++) begin
            cycle(1'b1, 17'(acc_cnt * 300 + 50), 16'(acc_cnt * 7), !(c >= 2 && c <= 7));
            if (c == 4) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (c == 7) check("stall_accepts", acc_cnt, 32'd2);
        end
        check("stream_accepts", acc_cnt, 32'd10);
        drain();
        check("stream_outputs", out_cnt, 32'd10);

        // Reset with two items in flight
        cycle(1'b1, 17'd100, 16'd200, 1'b0);
        cycle(1'b1, 17'd300, 16'd1, 1'b0);
        cycle(1'b0, 17'd0, 16'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_err", {24'd0, err_cnt}, 32'd0);
        sb.delete();
        err_exp       = 0;
        stall_pending = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_cnt = 0;
        send(17'd40, 16'd15);
        drain();
        check("post_rst_out", out_cnt, 32'd1);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 17'd5, 16'd9, 1'b1);
        drain();
        check("err_saturated", {24'd0, err_cnt}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
